// File: rtl/demux1x5x4bit_if.sv
// rtl/demux1x5x4bit_if.sv - write-port and channel-state bundle for the 1:5 nibble demux
interface demux1x5x4bit_if;
  logic [3:0] d;
  logic [2:0] a;
  logic       we;
  logic       auto;
  logic       clr;
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic [3:0] q4;
  logic [4:0] v;
  logic       full;
  logic [2:0] ptr;
  logic       frame;
  logic       err;

  modport master (
    output d, a, we, auto, clr,
    input  q0, q1, q2, q3, q4, v, full, ptr, frame, err
  );

  modport slave (
    input  d, a, we, auto, clr,
    output q0, q1, q2, q3, q4, v, full, ptr, frame, err
  );
endinterface

// File: rtl/demux1x5x4bit.sv
// rtl/demux1x5x4bit.sv - registered 1:5 demux for 4-bit data with round-robin pointer
module demux1x5x4bit (
  input  logic                 clk,
  input  logic                 rst,
  demux1x5x4bit_if.slave       bus
);

  logic [3:0] q_r [5];
  logic [4:0] v_r;
  logic [2:0] ptr_r;
  logic       frame_r;
  logic       err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) q_r[i] <= 4'd0;
      v_r     <= 5'd0;
      ptr_r   <= 3'd0;
      frame_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      frame_r <= 1'b0;
      err_r   <= 1'b0;
      // clr drops any concurrent write; holding registers keep their data
      if (bus.clr) begin
        v_r   <= 5'd0;
        ptr_r <= 3'd0;
      end else if (bus.we) begin
        if (bus.auto) begin
          q_r[ptr_r]   <= bus.d;
          v_r[ptr_r]   <= 1'b1;
          frame_r      <= (ptr_r == 3'd4);
          ptr_r        <= (ptr_r == 3'd4) ? 3'd0 : ptr_r + 3'd1;
        end else if (bus.a <= 3'd4) begin
          q_r[bus.a]   <= bus.d;
          v_r[bus.a]   <= 1'b1;
        end else begin
          err_r        <= 1'b1;
        end
      end
    end
  end

  assign bus.q0    = q_r[0];
  assign bus.q1    = q_r[1];
  assign bus.q2    = q_r[2];
  assign bus.q3    = q_r[3];
  assign bus.q4    = q_r[4];
  assign bus.v     = v_r;
  assign bus.full  = &v_r;
  assign bus.ptr   = ptr_r;
  assign bus.frame = frame_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_demux1x5x4bit.sv
// tb/tb_demux1x5x4bit.sv - scoreboard bench for demux1x5x4bit
module tb_demux1x5x4bit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  demux1x5x4bit_if bus ();

  demux1x5x4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [30:0] sb_q [$];

  logic [3:0] mq [5];
  logic [4:0] mv;
  logic [2:0] mp;
  logic       mf;
  logic       me;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] model_state();
    return {mq[0], mq[1], mq[2], mq[3], mq[4], mv, mp, mf, me, &mv};
  endfunction

  function automatic logic [30:0] dut_state();
    return {bus.q0, bus.q1, bus.q2, bus.q3, bus.q4, bus.v, bus.ptr, bus.frame, bus.err, bus.full};
  endfunction

  // Drive one cycle, predict the post-edge state, then compare after the edge.
  task automatic step(input logic r, input logic c, input logic w, input logic au,
                      input logic [2:0] aa, input logic [3:0] dd);
    logic [30:0] exp_s;
    @(negedge clk);
    rst = r; bus.clr = c; bus.we = w; bus.auto = au; bus.a = aa; bus.d = dd;
    if (r) begin
      for (int i = 0; i < 5; i++) mq[i] = 4'd0;
      mv = 5'd0; mp = 3'd0; mf = 1'b0; me = 1'b0;
    end else begin
      mf = 1'b0; me = 1'b0;
      if (c) begin
        mv = 5'd0; mp = 3'd0;
      end else if (w && au) begin
        mq[mp] = dd; mv[mp] = 1'b1; mf = (mp == 3'd4);
        mp = (mp == 3'd4) ? 3'd0 : mp + 3'd1;
      end else if (w) begin
        if (aa < 3'd5) begin mq[aa] = dd; mv[aa] = 1'b1; end
        else me = 1'b1;
      end
    end
    sb_q.push_back(model_state());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_s = sb_q.pop_front();
      check("state", {1'b0, dut_state()}, {1'b0, exp_s});
    end
  endtask

  logic [2:0] ptr_seq [7];
  logic [3:0] auto_d  [7];

  initial begin
    bus.d = 4'd0; bus.a = 3'd0; bus.we = 1'b0; bus.auto = 1'b0; bus.clr = 1'b0;
    for (int i = 0; i < 5; i++) mq[i] = 4'd0;
    mv = 5'd0; mp = 3'd0; mf = 1'b0; me = 1'b0;
    ptr_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    auto_d  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h6, 4'h7};

    // reset with a pending write
    step(1, 0, 1, 0, 3'd0, 4'hF);
    step(1, 0, 1, 0, 3'd0, 4'hF);
    check("rst_v", bus.v, 5'b00000);
    check("rst_full", bus.full, 1'b0);
    check("rst_q0", bus.q0, 4'h0);

    // manual writes to every channel
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 3'(i), 4'(i + 1));
    check("man_v", bus.v, 5'b11111);
    check("man_full", bus.full, 1'b1);
    check("man_ptr", bus.ptr, 3'd0);
    check("man_q", {bus.q0, bus.q1, bus.q2, bus.q3, bus.q4}, 20'h12345);

    // illegal addresses, back-to-back then idle
    step(0, 0, 1, 0, 3'd6, 4'h9);
    check("err_pulse", bus.err, 1'b1);
    check("err_q", {bus.q0, bus.q1, bus.q2, bus.q3, bus.q4}, 20'h12345);
    step(0, 0, 1, 0, 3'd7, 4'h9);
    check("err_b2b", bus.err, 1'b1);
    step(0, 0, 0, 0, 3'd0, 4'h0);
    check("err_drop", bus.err, 1'b0);

    // auto frame with wrap
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 1, 3'd0, auto_d[i]);
      check("auto_ptr", bus.ptr, ptr_seq[i]);
      check("auto_frame", bus.frame, (i == 4) ? 1'b1 : 1'b0);
    end
    check("auto_q", {bus.q0, bus.q1, bus.q2, bus.q3, bus.q4}, 20'h67CDE);

    // clear colliding with a write
    step(0, 0, 1, 1, 3'd0, 4'h1);
    check("pre_clr_ptr", bus.ptr, 3'd3);
    step(0, 1, 1, 1, 3'd0, 4'h8);
    check("clr_v", bus.v, 5'b00000);
    check("clr_ptr", bus.ptr, 3'd0);
    check("clr_q", {bus.q0, bus.q1, bus.q2, bus.q3, bus.q4}, 20'h671DE);
    step(0, 0, 1, 1, 3'd0, 4'h9);
    check("post_clr_q0", bus.q0, 4'h9);
    check("post_clr_v", bus.v, 5'b00001);

    // mode interleave
    step(0, 0, 1, 1, 3'd0, 4'h2);
    step(0, 0, 1, 0, 3'd4, 4'h3);
    check("mix_ptr_hold", bus.ptr, 3'd2);
    step(0, 0, 1, 1, 3'd0, 4'h5);
    check("mix_q4", bus.q4, 4'h3);
    check("mix_q2", bus.q2, 4'h5);
    check("mix_ptr", bus.ptr, 3'd3);

    // reset mid-frame
    step(0, 0, 1, 1, 3'd0, 4'h4);
    check("pre_rst_ptr", bus.ptr, 3'd4);
    step(1, 0, 1, 1, 3'd0, 4'hB);
    check("mrst_q4", bus.q4, 4'h0);
    check("mrst_frame", bus.frame, 1'b0);
    check("mrst_ptr", bus.ptr, 3'd0);
    step(0, 0, 1, 1, 3'd0, 4'hC);
    check("mrst_next_q0", bus.q0, 4'hC);
    check("mrst_next_ptr", bus.ptr, 3'd1);

    // random traffic against the scoreboard
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0),
           3'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
